// File: rtl/q2_io_pkg.sv
// q2_io_pkg
//   Shared constants for the q2 display/keypad I/O block: default decoded
//   I/O address, command bit positions inside the write word, default clear
//   character and the clear-engine state encoding.
package q2_io_pkg;

    localparam logic [11:0] IO_ADDR_DFLT = 12'hFFF;
    localparam logic [7:0]  FILL_DFLT    = 8'h20;

    // Bit positions inside a write word
    localparam int CMD_BIT     = 8;    // 0: character, 1: command
    localparam int SETADDR_BIT = 7;    // command: set cursor
    localparam int CLR_BIT     = 0;    // command (SETADDR_BIT=0): start clear

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/q2_char_ram.sv
// q2_char_ram
//   Simple dual-port character RAM, 8-bit data, registered read.
//   A read and a write to the same address on the same edge return the
//   old contents.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (read register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  registered read data
module q2_char_ram #(
    parameter int ABITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [2**ABITS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/q2_disp_io.sv
// q2_disp_io
//   Memory-mapped character display and keypad peripheral on the q2 bus.
//   Writes to IO_ADDR carry characters (stored at the cursor) or commands
//   (set cursor, clear). Reads from IO_ADDR return the inverted synchronised
//   keypad in the low bits and ~busy in the MSB; every other bit reads 1.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   abus       in   CPU address
//   din        in   CPU write data
//   dout       out  read data, 0 unless rdm and address hit
//   wrm        in   write strobe (level, acts once per high run)
//   rdm        in   read strobe
//   keys       in   raw keypad, active-high, asynchronous
//   scan_addr  in   display-driver read address
//   scan_char  out  character at scan_addr, one cycle latency
//   cursor     out  current write position
//   busy       out  clear in progress
//
// Clear engine states:
//   state    | meaning
//   ST_IDLE  | accepting CPU writes
//   ST_CLEAR | writing FILL to every RAM location, CPU writes dropped
module q2_disp_io
    import q2_io_pkg::*;
#(
    parameter int             DW       = 12,
    parameter int             AW       = 12,
    parameter logic [AW-1:0]  IO_ADDR  = AW'(IO_ADDR_DFLT),
    parameter int             CUR_BITS = 7,
    parameter int             KEYS     = 4,
    parameter logic [7:0]     FILL     = FILL_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       abus,
    input  logic [DW-1:0]       din,
    output logic [DW-1:0]       dout,
    input  logic                wrm,
    input  logic                rdm,
    input  logic [KEYS-1:0]     keys,
    input  logic [CUR_BITS-1:0] scan_addr,
    output logic [7:0]          scan_char,
    output logic [CUR_BITS-1:0] cursor,
    output logic                busy
);

    clr_state_e          state_q;
    logic [CUR_BITS-1:0] cnt_q;
    logic [CUR_BITS-1:0] cursor_q, cursor_d;
    logic                wrm_q;
    logic [KEYS-1:0]     keys_s1_q, keys_s2_q;

    logic                hit;
    logic                wr_acc;
    logic                cmd_char, cmd_set, cmd_clr;
    logic                clearing, clear_last;
    logic                ram_we;
    logic [CUR_BITS-1:0] ram_waddr;
    logic [7:0]          ram_wdata;
    logic                unused_din;

    assign hit      = (abus == IO_ADDR);
    assign clearing = (state_q == ST_CLEAR);
    assign clear_last = clearing && (cnt_q == '1);

    // Rising edge of the strobe only; anything arriving mid-clear is lost.
    assign wr_acc   = wrm && !wrm_q && hit && !clearing;
    assign cmd_char = wr_acc && !din[CMD_BIT];
    assign cmd_set  = wr_acc && din[CMD_BIT] && din[SETADDR_BIT];
    assign cmd_clr  = wr_acc && din[CMD_BIT] && !din[SETADDR_BIT] && din[CLR_BIT];

    assign unused_din = ^din[DW-1:CMD_BIT+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrm_q     <= 1'b0;
            keys_s1_q <= '0;
            keys_s2_q <= '0;
        end else begin
            wrm_q     <= wrm;
            keys_s1_q <= keys;
            keys_s2_q <= keys_s1_q;
        end
    end

    // Reset lands in ST_CLEAR so the RAM is always initialised to FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (clear_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cursor_d = cursor_q;
        if (clear_last) begin
            cursor_d = '0;
        end else if (cmd_char) begin
            cursor_d = cursor_q + 1'b1;
        end else if (cmd_set) begin
            cursor_d = din[CUR_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_q <= '0;
        end else begin
            cursor_q <= cursor_d;
        end
    end

    assign ram_we    = clearing || cmd_char;
    assign ram_waddr = clearing ? cnt_q : cursor_q;
    assign ram_wdata = clearing ? FILL : din[7:0];

    q2_char_ram #(
        .ABITS (CUR_BITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (scan_addr),
        .rdata_o (scan_char)
    );

    always_comb begin
        dout = '0;
        if (rdm && hit) begin
            dout             = '1;
            dout[KEYS-1:0]   = ~keys_s2_q;
            dout[DW-1]       = ~clearing;
        end
    end

    assign cursor = cursor_q;
    assign busy   = clearing;

endmodule

// File: tb/tb_q2_disp_io.sv
// tb_q2_disp_io
//   Directed bench for q2_disp_io with hand-computed expectations.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_q2_disp_io;

    localparam logic [11:0] IO  = 12'hFFF;
    localparam logic [11:0] OTH = 12'hFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] abus = IO;
    logic [11:0] din = '0;
    logic [11:0] dout;
    logic        wrm = 1'b0;
    logic        rdm = 1'b0;
    logic [3:0]  keys = '0;
    logic [6:0]  scan_addr = '0;
    logic [7:0]  scan_char;
    logic [6:0]  cursor;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    q2_disp_io dut (
        .clk       (clk),
        .rst       (rst),
        .abus      (abus),
        .din       (din),
        .dout      (dout),
        .wrm       (wrm),
        .rdm       (rdm),
        .keys      (keys),
        .scan_addr (scan_addr),
        .scan_char (scan_char),
        .cursor    (cursor),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] addr, input logic [11:0] data, input int hold);
        abus = addr;
        din  = data;
        wrm  = 1'b1;
        repeat (hold) @(negedge clk);
        wrm  = 1'b0;
        abus = IO;
        @(negedge clk);
    endtask

    task automatic scan_at(input logic [6:0] addr, output logic [7:0] val);
        scan_addr = addr;
        @(negedge clk);
        val = scan_char;
    endtask

    task automatic scan_fill(input string tag);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            scan_at(7'(i), v);
            if (v !== 8'h20) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;

        // reset state
        repeat (3) @(negedge clk);
        rdm = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_scan", 32'(scan_char), 32'd0);
        check("rst_dout", 32'(dout), 32'h7FF);
        rdm = 1'b0;

        // busy falls exactly 128 edges after release
        rst = 1'b0;
        repeat (127) @(negedge clk);
        check("rel_busy_127", 32'(busy), 32'd1);
        @(negedge clk);
        check("rel_busy_128", 32'(busy), 32'd0);
        check("rel_cursor", 32'(cursor), 32'd0);
        scan_fill("init_fill");

        // held strobe writes once
        bus_write(IO, 12'h041, 3);
        bus_write(IO, 12'h042, 3);
        check("hold_cursor", 32'(cursor), 32'd2);
        scan_at(7'd0, v); check("ram0", 32'(v), 32'h41);
        scan_at(7'd1, v); check("ram1", 32'(v), 32'h42);
        scan_at(7'd2, v); check("ram2", 32'(v), 32'h20);

        // set cursor, writes, wrap
        bus_write(IO, 12'h1C0, 1);
        check("set64", 32'(cursor), 32'd64);
        bus_write(IO, 12'h048, 1);
        bus_write(IO, 12'h049, 1);
        check("cursor66", 32'(cursor), 32'd66);
        scan_at(7'd64, v); check("ram64", 32'(v), 32'h48);
        scan_at(7'd65, v); check("ram65", 32'(v), 32'h49);
        bus_write(IO, 12'h1FF, 1);
        check("set127", 32'(cursor), 32'd127);
        bus_write(IO, 12'h05A, 1);
        check("wrap", 32'(cursor), 32'd0);
        scan_at(7'd127, v); check("ram127", 32'(v), 32'h5A);

        // no-op command and address miss
        bus_write(IO, 12'h100, 1);
        check("noop_cursor", 32'(cursor), 32'd0);
        check("noop_busy", 32'(busy), 32'd0);
        bus_write(OTH, 12'h043, 1);
        check("miss_cursor", 32'(cursor), 32'd0);
        scan_at(7'd0, v); check("miss_ram0", 32'(v), 32'h41);

        // same-address collision returns old data, new one a cycle later
        bus_write(IO, 12'h183, 1);
        scan_addr = 7'd3;
        @(negedge clk);
        din = 12'h05A; abus = IO; wrm = 1'b1;
        @(negedge clk);
        check("coll_old", 32'(scan_char), 32'h20);
        wrm = 1'b0;
        @(negedge clk);
        check("coll_new", 32'(scan_char), 32'h5A);
        check("coll_cursor", 32'(cursor), 32'd4);

        // keypad through two-flop synchroniser
        abus = IO; rdm = 1'b1;
        keys = 4'b0100;
        @(negedge clk);
        check("key_1edge", 32'(dout), 32'hFFF);
        @(negedge clk);
        check("key_2edge", 32'(dout), 32'hFFB);
        abus = OTH;
        #1;
        check("key_miss", 32'(dout), 32'h000);
        abus = IO; rdm = 1'b0;
        #1;
        check("key_nordm", 32'(dout), 32'h000);

        // clear with a dropped write at +5 and a read while busy
        din = 12'h101; wrm = 1'b1;
        @(negedge clk);
        wrm = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 300) begin
            wrm = 1'b0; rdm = 1'b0;
            if (n == 4) begin din = 12'h041; wrm = 1'b1; end
            if (n == 6) begin din = 12'h101; wrm = 1'b1; end
            if (n == 20) begin
                rdm = 1'b1; #1;
                check("clr_dout", 32'(dout), 32'h7FB);
            end
            @(negedge clk);
            n++;
        end
        wrm = 1'b0; rdm = 1'b1;
        #1;
        check("clr_len", 32'(n), 32'd128);
        check("clr_cursor", 32'(cursor), 32'd0);
        check("idle_dout", 32'(dout), 32'hFFB);
        rdm = 1'b0;
        scan_fill("clr_fill");
        @(negedge clk);
        check("clr_no_second", 32'(busy), 32'd0);

        // reset in the middle of a clear restarts it
        bus_write(IO, 12'h051, 1);
        check("pre_rst_cursor", 32'(cursor), 32'd1);
        din = 12'h101; wrm = 1'b1;
        @(negedge clk);
        wrm = 1'b0;
        repeat (59) @(negedge clk);
        rst = 1'b1; rdm = 1'b1;
        @(negedge clk);
        check("mid_rst_cursor", 32'(cursor), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_dout", 32'(dout), 32'h7FF);
        @(negedge clk);
        rst = 1'b0; rdm = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rst_clr_len", 32'(n), 32'd128);
        scan_fill("rst_fill");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/q2_disp_io.md
# q2_disp_io

Synthesizable memory-mapped character-display and keypad peripheral for the q2 CPU bus. It decodes one I/O word address: writes carry characters or display commands, reads return keypad state and a busy flag. It generalises the fixed 16x2, single-key behaviour into a parametrised block with an internal character RAM, a multi-cycle clear engine, and a scan-out port for a display driver. It sits beside main RAM on the q2 address/data bus.

## Interface
- `DW`, 12: bus data width (≥ 10)
- `AW`, 12: bus address width
- `IO_ADDR`, 12'hFFF: decoded I/O address
- `CUR_BITS`, 7: cursor/RAM address bits; depth = 2^CUR_BITS
- `KEYS`, 4: keypad inputs (≤ DW-1)
- `FILL`, 8'h20: clear character

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `abus` in AW: CPU address
- `din` in DW: CPU write data
- `dout` out DW: read data; 0 unless `rdm` and address hit
- `wrm` in 1: CPU write strobe, level
- `rdm` in 1: CPU read strobe, level
- `keys` in KEYS: raw keypad, active-high pressed, asynchronous
- `scan_addr` in CUR_BITS: display-driver read address
- `scan_char` out 8: character at `scan_addr`, registered
- `cursor` out CUR_BITS: current write position
- `busy` out 1: clear in progress

## Operation
- Write accepted only on the first cycle of a `wrm` high run with `abus == IO_ADDR`; a registered `wrm` delay gives the rising-edge detect. A held strobe acts once.
- Decode of an accepted write:
  - `din[8]=0`: character. Write `din[7:0]` to RAM[cursor]; cursor <= cursor+1 mod 2^CUR_BITS.
  - `din[8]=1, din[7]=1`: set cursor = `din[CUR_BITS-1:0]`.
  - `din[8]=1, din[7]=0, din[0]=1`: start clear.
  - `din[8]=1`, other values: no operation.
- Clear engine, states IDLE/CLEAR:
  - IDLE->CLEAR on the clear command. Counter starts at 0.
  - In CLEAR, write FILL to RAM[counter] once per cycle and increment the counter.
  - CLEAR->IDLE after address 2^CUR_BITS-1 is written; cursor <= 0 on exit.
  - Accepted writes while busy are dropped entirely, including a second clear.
- Read, combinational when `rdm` and the address hits:
  - `dout[KEYS-1:0] = ~keys_sync`.
  - `dout[DW-1] = ~busy`.
  - All other bits = 1.
  - Idle with one key k pressed reads `(1<<k) ^ {DW{1'b1}}`.
- `keys` pass through a 2-flop synchroniser.
- Character RAM is simple dual-port: the write port serves CPU and clear, the read port serves scan. Read-first on a same-address collision.
- Reset: state forced to CLEAR with counter 0, cursor 0, `busy` 1, sync flops 0, edge-detect flop 0, `scan_char` 0. Asserting reset mid-clear restarts the clear from 0.

## Timing
- Character write: strobe sampled at edge t; RAM and cursor update at t. `scan_char` shows the new value at edge t+1 if `scan_addr` matches.
- Clear command accepted at edge t:
  - `busy`=1 from t.
  - RAM[i] written at edge t+1+i.
  - `busy`=0 and cursor=0 after edge t+2^CUR_BITS.
- Reset released at edge r: `busy` low after edge r+2^CUR_BITS.
- Keys: a change at the input shows in `dout` after 2 edges.
- `scan_char` latency: 1 cycle.
- Cursor wraps from 2^CUR_BITS-1 to 0 with no flag.

## Structure
- Package `q2_io_pkg`: `IO_ADDR` default, command bit positions (`CMD_BIT`=8, `SETADDR_BIT`=7, `CLR_BIT`=0), `FILL` default, clear-state enum.
- Sub-module `q2_char_ram`: parametrised simple dual-port RAM, 8-bit data, CUR_BITS address, registered read.
- Top level holds decode, edge detect, FSM, cursor, synchroniser and read mux.

## Test plan
- Reset, hold 128 cycles -> `busy` falls exactly 128 cycles after reset release; scan of addresses 0..127 returns 8'h20.
- Idle, write 0x041 then 0x042 with `wrm` held 3 cycles each -> RAM[0]=0x41, RAM[1]=0x42, cursor=2 (one write per strobe).
- Write 0x1C0 (set 64), 0x048, 0x049 -> RAM[64]=0x48, RAM[65]=0x49; set 127, write 0x05A -> RAM[127]=0x5A, cursor wraps to 0.
- Clear command, then write 0x041 at cycle +5 -> write dropped; all 128 locations read 0x20; cursor=0 after completion.
- `keys`=4'b0100 while idle -> read at 0xFFF returns 0xFFB after 2 cycles; during clear, same keys -> 0x7FB; read at 0xFFE -> 0x000.
- Assert reset at clear cycle 60 -> clear restarts; `busy` stays high a further 128 cycles after release.
